// File: rtl/sync_fifo_flex.sv
// Synchronous FIFO on a circular buffer, with a registered-read or first-word-fall-through
// output, occupancy-based status flags and sticky overflow/underflow flags.
module sync_fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 16,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DATA_DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          rd_valid,
  output logic                          full,
  output logic                          empty,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [$clog2(DATA_DEPTH):0]   fifo_cnt,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int AW = $clog2(DATA_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DATA_DEPTH);
  localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          rd_accept, wr_accept;

  // Status flags depend only on the registered count.
  assign full         = (cnt_q == FULL_C);
  assign empty        = (cnt_q == '0);
  assign almost_full  = (cnt_q >= AF_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign fifo_cnt     = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

  // A read in the same cycle frees a slot, so a write into a full FIFO is still accepted.
  assign rd_accept = rd_en && !empty;
  assign wr_accept = wr_en && (!full || rd_accept);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_accept) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_accept, rd_accept})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
      ovf_d = ovf_q | (wr_en && !wr_accept);
      udf_d = udf_q | (rd_en && empty);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (wr_accept && !flush) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  rv_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q <= '0;
          rv_q   <= 1'b0;
        end else if (flush) begin
          rv_q <= 1'b0;
        end else if (rd_accept) begin
          dout_q <= mem_q[rd_ptr_q];
          rv_q   <= 1'b1;
        end else begin
          rv_q <= 1'b0;
        end
      end

      assign data_out = dout_q;
      assign rd_valid = rv_q;
    end else begin : g_fwft_read
      // Head word is presented directly; forced to zero while empty so reset reads as zero.
      assign data_out = empty ? '0 : mem_q[rd_ptr_q];
      assign rd_valid = !empty;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench for sync_fifo_flex: one standard-read instance and one FWFT instance.
module tb_sync_fifo_flex;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  logic       wr0 = 1'b0, rd0 = 1'b0;
  logic [7:0] din0 = '0;
  logic [7:0] dout0;
  logic       rv0, full0, empty0, af0, ae0, ovf0, udf0;
  logic [4:0] cnt0;

  logic       wr1 = 1'b0, rd1 = 1'b0;
  logic [7:0] din1 = '0;
  logic [7:0] dout1;
  logic       rv1, full1, empty1, af1, ae1, ovf1, udf1;
  logic [4:0] cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.DATA_WIDTH(8), .DATA_DEPTH(16), .FWFT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr0), .data_in(din0), .rd_en(rd0),
    .data_out(dout0), .rd_valid(rv0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .fifo_cnt(cnt0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_flex #(.DATA_WIDTH(8), .DATA_DEPTH(16), .FWFT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr1), .data_in(din1), .rd_en(rd1),
    .data_out(dout1), .rd_valid(rv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .fifo_cnt(cnt1),
    .overflow(ovf1), .underflow(udf1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_cnt", cnt0, 0);
    check("rst_empty", empty0, 1);
    check("rst_full", full0, 0);
    check("rst_ae", ae0, 1);
    check("rst_af", af0, 0);
    check("rst_dout", dout0, 0);
    check("rst_rv", rv0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_udf", udf0, 0);
    check("rst_rv1", rv1, 0);
    rst_n = 1'b1;
    tick();

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      wr0 = 1'b1; din0 = 8'(i);
      tick();
      $display("wr 0x%02h cnt=%0d full=%0d af=%0d ae=%0d", din0, cnt0, full0, af0, ae0);
      check("fill_cnt", cnt0, i);
      check("fill_full", full0, (i == 16) ? 1 : 0);
      check("fill_af", af0, (i >= 14) ? 1 : 0);
      check("fill_ae", ae0, (i <= 2) ? 1 : 0);
    end
    din0 = 8'h11;
    tick();
    wr0 = 1'b0;
    $display("wr 0x11 on full: ovf=%0d cnt=%0d", ovf0, cnt0);
    check("ovf_set", ovf0, 1);
    check("ovf_cnt", cnt0, 16);

    // Drain in order
    for (int i = 1; i <= 16; i++) begin
      rd0 = 1'b1;
      tick();
      $display("rd 0x%02h rv=%0d cnt=%0d", dout0, rv0, cnt0);
      check("drain_data", dout0, i);
      check("drain_rv", rv0, 1);
      check("drain_cnt", cnt0, 16 - i);
    end
    tick();
    rd0 = 1'b0;
    $display("rd on empty: udf=%0d dout=0x%02h rv=%0d", udf0, dout0, rv0);
    check("udf_set", udf0, 1);
    check("udf_dout_hold", dout0, 8'h10);
    check("udf_rv", rv0, 0);
    check("udf_empty", empty0, 1);

    // Flush clears sticky flags
    flush = 1'b1;
    tick();
    flush = 1'b0;
    $display("flush: ovf=%0d udf=%0d cnt=%0d", ovf0, udf0, cnt0);
    check("flush_ovf", ovf0, 0);
    check("flush_udf", udf0, 0);
    check("flush_cnt", cnt0, 0);

    // Full FIFO with simultaneous read/write across pointer wrap
    for (int i = 0; i < 16; i++) begin
      wr0 = 1'b1; din0 = 8'(8'h20 + i);
      tick();
    end
    check("sim_full", full0, 1);
    rd0 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din0 = 8'(8'h30 + k);
      tick();
      $display("wr+rd 0x%02h -> 0x%02h cnt=%0d", din0, dout0, cnt0);
      check("sim_data", dout0, (k < 16) ? (8'h20 + k) : (8'h30 + k - 16));
      check("sim_cnt", cnt0, 16);
      check("sim_ovf", ovf0, 0);
    end
    wr0 = 1'b0; rd0 = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;

    // Empty with read and write together
    wr0 = 1'b1; rd0 = 1'b1; din0 = 8'h55;
    tick();
    rd0 = 1'b0;
    $display("wr+rd on empty: cnt=%0d udf=%0d", cnt0, udf0);
    check("er_cnt", cnt0, 1);
    check("er_udf", udf0, 1);
    check("er_ovf", ovf0, 0);
    flush = 1'b1; din0 = 8'h66;
    tick();
    flush = 1'b0; wr0 = 1'b0;
    $display("flush with wr: cnt=%0d udf=%0d", cnt0, udf0);
    check("fw_cnt", cnt0, 0);
    check("fw_udf", udf0, 0);
    check("fw_empty", empty0, 1);
    tick();
    check("fw_dropped", cnt0, 0);

    // FWFT instance
    wr1 = 1'b1; din1 = 8'hA5;
    tick();
    wr1 = 1'b0;
    $display("fwft wr 0xA5: rv=%0d dout=0x%02h", rv1, dout1);
    check("fwft_rv", rv1, 1);
    check("fwft_data", dout1, 8'hA5);
    tick();
    check("fwft_hold", dout1, 8'hA5);
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
    $display("fwft rd: empty=%0d rv=%0d", empty1, rv1);
    check("fwft_empty", empty1, 1);
    check("fwft_rv_low", rv1, 0);
    wr1 = 1'b1; din1 = 8'hB1;
    tick();
    din1 = 8'hB2;
    tick();
    wr1 = 1'b0;
    check("fwft_head1", dout1, 8'hB1);
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
    $display("fwft rd: dout=0x%02h cnt=%0d", dout1, cnt1);
    check("fwft_head2", dout1, 8'hB2);
    check("fwft_cnt", cnt1, 1);

    // Asynchronous reset mid-operation at cnt=8
    for (int i = 0; i < 9; i++) begin
      wr0 = 1'b1; din0 = 8'(8'h61 + i);
      tick();
    end
    wr0 = 1'b0; rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    check("pre_rst_cnt", cnt0, 8);
    check("pre_rst_dout", dout0, 8'h61);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async rst: cnt=%0d dout=0x%02h empty=%0d", cnt0, dout0, empty0);
    check("arst_cnt", cnt0, 0);
    check("arst_dout", dout0, 0);
    check("arst_empty", empty0, 1);
    check("arst_ae", ae0, 1);
    check("arst_rv", rv0, 0);
    check("arst_cnt1", cnt1, 0);
    tick();
    rst_n = 1'b1;
    wr0 = 1'b1; din0 = 8'h77;
    tick();
    wr0 = 1'b0; rd0 = 1'b1;
    tick();
    rd0 = 1'b0;
    $display("post rst wr/rd: dout=0x%02h cnt=%0d", dout0, cnt0);
    check("post_rst_data", dout0, 8'h77);
    check("post_rst_cnt", cnt0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
SYNC_FIFO_FLEX -- requirements
Module: sync_fifo_flex

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DATA_DEPTH, default 16, number of entries; power of two, >=2.
REQ-003 Parameter FWFT, default 0; 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 Parameter AF_LEVEL, default DATA_DEPTH-2, almost_full threshold (1..DATA_DEPTH).
REQ-005 Parameter AE_LEVEL, default 2, almost_empty threshold (0..DATA_DEPTH-1).
REQ-006 clk  input  1  clock, all state on rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 flush  input  1  synchronous clear of contents and error flags.
REQ-009 wr_en  input  1  write request.
REQ-010 data_in  input  DATA_WIDTH  write data.
REQ-011 rd_en  input  1  read request (FWFT=1: acknowledge of head word).
REQ-012 data_out  output  DATA_WIDTH  read data.
REQ-013 rd_valid  output  1  data_out holds a valid read word.
REQ-014 full / empty  output  1 each  count==DATA_DEPTH / count==0.
REQ-015 almost_full / almost_empty  output  1 each  count>=AF_LEVEL / count<=AE_LEVEL.
REQ-016 fifo_cnt  output  $clog2(DATA_DEPTH)+1  current occupancy.
REQ-017 overflow / underflow  output  1 each  sticky error flags.

Function
REQ-018 Storage SHALL be a circular buffer with wr_ptr/rd_ptr of $clog2(DATA_DEPTH) bits, each incrementing modulo DATA_DEPTH on accept.
REQ-019 Read accept SHALL be rd_en && !empty; write accept SHALL be wr_en && (!full || rd_accept).
REQ-020 Simultaneous accepted read and write SHALL leave fifo_cnt unchanged, including at full (write into freed slot).
REQ-021 Empty with wr_en and rd_en both high: write accepted, read rejected, underflow set; fifo_cnt +1.
REQ-022 fifo_cnt SHALL be +1 write-only, -1 read-only, never exceed DATA_DEPTH nor go below 0.
REQ-023 Flags full/empty/almost_* SHALL be combinational from registered fifo_cnt only.
REQ-024 overflow SHALL set on wr_en && !write_accept; underflow on rd_en && empty; both hold until flush or reset.
REQ-025 FWFT=0: on read accept, data_out SHALL load mem[rd_ptr] at that edge; rd_valid high the following cycle only; data_out held otherwise.
REQ-026 FWFT=1: data_out SHALL equal mem[rd_ptr] whenever !empty; rd_valid SHALL equal !empty; zero-latency from a write into an empty FIFO is not required -- word appears the cycle after the write edge.
REQ-027 FWFT=1, data_out while empty is don't-care.
REQ-028 flush SHALL, at the clock edge, zero pointers, fifo_cnt, overflow, underflow and rd_valid; it overrides wr_en/rd_en that cycle; data_out retains its value.
REQ-029 Memory contents need no reset; reads only return previously written data.

Reset
REQ-030 While rst_n low: pointers, fifo_cnt, overflow, underflow, rd_valid, data_out = 0; empty=1, full=0, almost_empty=1, almost_full=0.
REQ-031 Reset assertion mid-operation SHALL discard all contents immediately; first accepted write after release goes to entry 0.

Verification
REQ-032 DEPTH=16, FWFT=0: write 16 words 0x01..0x10 -> full=1 at cnt=16, almost_full at cnt=14; 17th write -> overflow=1, cnt stays 16.
REQ-033 FWFT=0: read 16 -> data_out 0x01..0x10 in order, each one cycle after rd_en, rd_valid pulse; 17th read -> underflow=1, data_out holds 0x10.
REQ-034 Full FIFO, wr_en+rd_en together for 20 cycles -> cnt stays 16, no overflow, output order preserved across pointer wrap.
REQ-035 FWFT=1: write 0xA5 to empty -> next cycle rd_valid=1, data_out=0xA5 without rd_en; rd_en -> empty=1 next cycle.
REQ-036 Empty, wr_en+rd_en same cycle -> cnt=1, underflow=1; then flush with wr_en high -> cnt=0, flags cleared, write dropped.
REQ-037 cnt=8, assert rst_n low mid-cycle -> outputs at reset values immediately, no clock edge required.
